// File: rtl/key_debounce.sv
// -----------------------------------------------------------------------------
// key_debounce
//
// Input conditioning for active-low pushbuttons. Each key passes through a
// two-flop synchroniser and then a stability counter. The clean level flips
// only after the synchronised key has differed from it for DEBOUNCE_CYCLES
// consecutive clocks. On the flip edge, a one-cycle press strobe (clean 1->0)
// or release strobe (clean 0->1) is emitted.
//
// Ports:
//   clk          system clock
//   rst_n        asynchronous active-low reset
//   key_raw      raw key levels, active-low, asynchronous to clk
//   key_clean    debounced level, active-low, registered (bit0 = key1)
//   key_press    one-cycle strobe on clean 1->0, registered
//   key_release  one-cycle strobe on clean 0->1, registered
// -----------------------------------------------------------------------------
module key_debounce #(
    parameter int unsigned N_KEYS          = 4,
    parameter int unsigned DEBOUNCE_CYCLES = 1000000
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [N_KEYS-1:0] key_raw,
    output logic [N_KEYS-1:0] key_clean,
    output logic [N_KEYS-1:0] key_press,
    output logic [N_KEYS-1:0] key_release
);

    localparam int unsigned      CNT_W   = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [N_KEYS-1:0] s1_q;
    logic [N_KEYS-1:0] s2_q;
    logic [N_KEYS-1:0] clean_q;
    logic [N_KEYS-1:0] clean_d;
    logic [N_KEYS-1:0] press_q;
    logic [N_KEYS-1:0] press_d;
    logic [N_KEYS-1:0] release_q;
    logic [N_KEYS-1:0] release_d;
    logic [CNT_W-1:0]  cnt_q [N_KEYS];
    logic [CNT_W-1:0]  cnt_d [N_KEYS];

    // Two-flop synchroniser. It resets to released so that a key held
    // through reset is seen as a fresh press.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_q <= '1;
            s2_q <= '1;
        end else begin
            s1_q <= key_raw;
            s2_q <= s1_q;
        end
    end

    // Per-key stability counter. Any cycle that agrees with the clean level
    // clears the count, so a glitch restarts the full debounce window.
    always_comb begin
        clean_d   = clean_q;
        press_d   = '0;
        release_d = '0;
        for (int unsigned i = 0; i < N_KEYS; i++) begin
            cnt_d[i] = '0;
            if (s2_q[i] != clean_q[i]) begin
                if (cnt_q[i] == CNT_MAX) begin
                    clean_d[i]   = s2_q[i];
                    press_d[i]   = ~s2_q[i];
                    release_d[i] = s2_q[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + CNT_W'(1);
                end
            end
        end
    end

    // Clean level, strobes and counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            clean_q   <= '1;
            press_q   <= '0;
            release_q <= '0;
            for (int unsigned i = 0; i < N_KEYS; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            clean_q   <= clean_d;
            press_q   <= press_d;
            release_q <= release_d;
            for (int unsigned i = 0; i < N_KEYS; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    assign key_clean   = clean_q;
    assign key_press   = press_q;
    assign key_release = release_q;

endmodule

// File: tb/tb_key_debounce.sv
module tb_key_debounce;

    localparam int unsigned N_KEYS = 4;
    localparam int unsigned DEB    = 8;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [N_KEYS-1:0] key_raw = 4'hF;
    logic [N_KEYS-1:0] key_clean;
    logic [N_KEYS-1:0] key_press;
    logic [N_KEYS-1:0] key_release;

    always #5 clk = ~clk;

    key_debounce #(
        .N_KEYS         (N_KEYS),
        .DEBOUNCE_CYCLES(DEB)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .key_raw    (key_raw),
        .key_clean  (key_clean),
        .key_press  (key_press),
        .key_release(key_release)
    );

    typedef struct {
        int         due;
        logic [3:0] clean;
        logic [3:0] press;
        logic [3:0] rel;
        string      tag;
    } exp_t;

    typedef struct {
        logic [3:0] raw;
        logic [3:0] clean_before;
        logic [3:0] clean_after;
        logic [3:0] press;
        logic [3:0] rel;
        string      tag;
    } vec_t;

    exp_t sb[$];
    exp_t cur;
    vec_t vecs[6];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   cyc = 0;
    int   press1_cnt = 0;

    // Edge counter: after posedge k settles, cyc == k.
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [3:0] c, input logic [3:0] p,
                         input logic [3:0] r, input logic [3:0] ec, input logic [3:0] ep,
                         input logic [3:0] er);
        n_cmp++;
        if ({c, p, r} !== {ec, ep, er}) begin
            n_bad++;
            $display("FAIL %s @cyc %0d: got clean=%h press=%h rel=%h, want clean=%h press=%h rel=%h",
                     tag, cyc, c, p, r, ec, ep, er);
        end
    endtask

    // Scoreboard consumer: compares outputs against queued expectations.
    always @(posedge clk) begin
        #1;
        if (key_press[1]) press1_cnt++;
        n_cmp++;
        if ((key_press & key_release) !== 4'h0) begin
            n_bad++;
            $display("FAIL press_release_overlap @cyc %0d: got press=%h rel=%h, want no common bit",
                     cyc, key_press, key_release);
        end
        while (sb.size() > 0 && sb[0].due <= cyc) begin
            cur = sb.pop_front();
            check(cur.tag, key_clean, key_press, key_release, cur.clean, cur.press, cur.rel);
        end
    end

    task automatic push(input int due, input logic [3:0] c, input logic [3:0] p,
                        input logic [3:0] r, input string tag);
        exp_t e;
        e.due = due; e.clean = c; e.press = p; e.rel = r; e.tag = tag;
        sb.push_back(e);
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Drive a new raw value; e0 is the index of the edge that first samples it.
    task automatic drive(input logic [3:0] raw, output int e0);
        @(negedge clk);
        key_raw = raw;
        e0 = cyc + 1;
    endtask

    // Hold raw stable and expect the flip exactly DEB+1 edges after sampling.
    task automatic apply(input vec_t v);
        int e0;
        drive(v.raw, e0);
        push(e0 + 8,  v.clean_before, 4'h0, 4'h0, {v.tag, "_before"});
        push(e0 + 9,  v.clean_after,  v.press, v.rel, {v.tag, "_flip"});
        push(e0 + 10, v.clean_after,  4'h0, 4'h0, {v.tag, "_after"});
        idle(12);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int e0;
        int ef;
        int base;
        vec_t v;

        vecs[0] = '{4'hE, 4'hF, 4'hE, 4'h1, 4'h0, "press_k0"};
        vecs[1] = '{4'hF, 4'hE, 4'hF, 4'h0, 4'h1, "release_k0"};
        vecs[2] = '{4'h0, 4'hF, 4'h0, 4'hF, 4'h0, "press_all"};
        vecs[3] = '{4'hF, 4'h0, 4'hF, 4'h0, 4'hF, "release_all"};
        vecs[4] = '{4'hB, 4'hF, 4'hB, 4'h4, 4'h0, "press_k2"};
        vecs[5] = '{4'hF, 4'hB, 4'hF, 4'h0, 4'h4, "release_k2"};

        // Initial reset.
        idle(3);
        check("reset_init", key_clean, key_press, key_release, 4'hF, 4'h0, 4'h0);
        @(negedge clk);
        rst_n = 1'b1;
        idle(3);

        for (int i = 0; i < 6; i++) apply(vecs[i]);

        // Bounce on key1: low 5 cycles, high 1, then low and held.
        base = press1_cnt;
        drive(4'hD, e0);
        idle(4);
        drive(4'hF, e0);
        drive(4'hD, ef);
        push(ef + 8,  4'hF, 4'h0, 4'h0, "bounce_before");
        push(ef + 9,  4'hD, 4'h2, 4'h0, "bounce_flip");
        push(ef + 10, 4'hD, 4'h0, 4'h0, "bounce_after");
        idle(12);
        n_cmp++;
        if (press1_cnt - base != 1) begin
            n_bad++;
            $display("FAIL bounce_pulse_count: got %0d press pulses, want 1", press1_cnt - base);
        end
        v = '{4'hF, 4'hD, 4'hF, 4'h0, 4'h2, "bounce_release"};
        apply(v);

        // Async reset landing on the cycle a press strobe is high.
        drive(4'h0, e0);
        push(e0 + 9, 4'h0, 4'hF, 4'h0, "pre_reset_flip");
        idle(10);
        rst_n = 1'b0;
        #1;
        check("reset_async", key_clean, key_press, key_release, 4'hF, 4'h0, 4'h0);
        key_raw = 4'hF;
        idle(3);
        check("reset_hold", key_clean, key_press, key_release, 4'hF, 4'h0, 4'h0);
        @(negedge clk);
        rst_n = 1'b1;
        idle(12);
        check("post_reset_idle", key_clean, key_press, key_release, 4'hF, 4'h0, 4'h0);

        // Key3 held low through a reset pulse.
        @(negedge clk);
        key_raw = 4'h7;
        rst_n = 1'b0;
        idle(3);
        check("reset_held_k3", key_clean, key_press, key_release, 4'hF, 4'h0, 4'h0);
        @(negedge clk);
        rst_n = 1'b1;
        e0 = cyc + 1;
        push(e0 + 8,  4'hF, 4'h0, 4'h0, "held_k3_before");
        push(e0 + 9,  4'h7, 4'h8, 4'h0, "held_k3_flip");
        push(e0 + 10, 4'h7, 4'h0, 4'h0, "held_k3_after");
        idle(12);
        v = '{4'hF, 4'h7, 4'hF, 4'h0, 4'h8, "release_k3"};
        apply(v);

        idle(3);
        n_cmp++;
        if (sb.size() != 0) begin
            n_bad++;
            $display("FAIL sb_drain: got %0d pending expectations, want 0", sb.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/key_debounce.md
Name: key_debounce

Overview:
- Input-conditioning stage for the four active-low board pushbuttons.
- Sits directly upstream of the colour-select logic and feeds it clean, glitch-free, active-low key levels.
- Also produces one-cycle press and release strobes for sequential consumers such as paddle and game-state logic.
- Each key is handled independently: two-flop synchroniser, then a per-key stability counter.

Parameters:
- N_KEYS, 4, number of independent key channels.
- DEBOUNCE_CYCLES, 1000000, consecutive clk cycles a synchronised key must differ from its clean level before the clean level flips (20 ms at 50 MHz). Minimum value 1.
- CNT_W, $clog2(DEBOUNCE_CYCLES+1), stability counter width (derived; do not override).

Ports:
- clk  input  1  system clock (pixel/system clock domain).
- rst_n  input  1  asynchronous active-low reset.
- key_raw  input  N_KEYS  raw pushbutton levels, active-low (0 = pressed), asynchronous to clk.
- key_clean  output  N_KEYS  debounced level, active-low, registered.
- key_press  output  N_KEYS  one-cycle pulse on clean 1->0 (press), registered.
- key_release  output  N_KEYS  one-cycle pulse on clean 0->1 (release), registered.

Behaviour:
- Clock and reset:
  - Single clock domain.
  - Reset is asynchronous and active-low.
- Reset values (applied immediately on rst_n low):
  - sync stage 1 and stage 2 flops = all 1.
  - key_clean = all 1 (released).
  - key_press = 0, key_release = 0.
  - All counters = 0.
- Synchroniser:
  - key_raw[i] -> s1[i] -> s2[i], two flops per key.
  - Only s2 is used downstream; key_raw is never used combinationally.
- Per-key counter, evaluated every clk edge:
  - If s2[i] == key_clean[i]: cnt[i] <= 0, no pulse.
  - Else if cnt[i] == DEBOUNCE_CYCLES-1:
    - key_clean[i] <= s2[i], cnt[i] <= 0.
    - Assert key_press[i] (if s2[i]==0) or key_release[i] (if s2[i]==1) for that one cycle.
  - Else: cnt[i] <= cnt[i]+1.
- Counter limits: cnt never exceeds DEBOUNCE_CYCLES-1 and never wraps.
- Pulses:
  - key_press and key_release are deasserted on every edge where no flip occurs, so a pulse is exactly one cycle wide.
  - key_press[i] and key_release[i] are never high together.
- Latency: if key_raw[i] changes and stays stable from sampling edge E0, key_clean[i] and the pulse update on edge E0 + DEBOUNCE_CYCLES + 1.
- Glitch rejection: any single cycle where s2 returns to the clean level clears the counter, and the full count restarts.
- Key independence: channels share nothing but clk/rst_n. Simultaneous changes on multiple keys debounce in parallel and may pulse on the same edge.
- Reset mid-count: the count is discarded and clean returns to 1.
- Key held low through reset release: treated as a new press. key_press fires DEBOUNCE_CYCLES+1 edges after the first sampling edge following reset deassertion.
- Pass-through to the colour-select logic: key_clean bit order matches key1..key4 = bit0..bit3, active-low preserved.

Test Plan (DEBOUNCE_CYCLES=8 for simulation):
- Reset: assert rst_n=0 mid-run with key_raw=4'h0 -> key_clean=4'hF, key_press=0, key_release=0 immediately, without waiting for a clk edge.
- Clean press: key_raw[0] 1->0 sampled at edge E0 and held -> key_clean[0]=0 and key_press[0]=1 at edge E0+9. key_press[0]=0 at E0+10. No other bits change.
- Bounce: key_raw[1] low for 5 cycles, high 1 cycle, low again and held -> no change before 9 edges after the final fall. Then key_clean[1]=0 with exactly one key_press[1] pulse.
- Release: from key_clean[2]=0, key_raw[2] 0->1 held -> key_clean[2]=1 and key_release[2]=1 for one cycle at E0+9. key_press[2] stays 0 throughout.
- Simultaneous keys: key_raw 4'hF->4'h0 on one edge -> all four clean bits fall and key_press=4'hF on the same edge E0+9.
- Held through reset: key_raw[3]=0 continuously, pulse rst_n low then release -> key_clean[3]=1 after reset. key_press[3] pulses once, 9 edges after the first post-reset sampling edge.
